// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS core with one unified req/ready memory port.
// Illegal opcodes and misaligned accesses raise a sticky fault.
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          ADDR_W        = 32,
  parameter bit          HALT_ON_FAULT = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              retire,
  output logic              fault,
  output logic              halted,
  output logic [31:0]       pc_out
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_FAULT  = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [31:0]       alu_q, alu_d;
  logic [31:0]       mdr_q, mdr_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              fault_q, fault_d;

  logic [31:0] rf [32];
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd;
  logic [31:0] sext, rs_val, rt_val;
  logic        is_r;
  logic        i_add, i_sub, i_and, i_or, i_slt, i_jr;
  logic        i_addi, i_lw, i_sw, i_beq, i_bne, i_j, i_jal;
  logic        legal, go_fetch, br_take;
  logic [31:0] alu_res;

  assign op   = ir_q[31:26];
  assign rs   = ir_q[25:21];
  assign rt   = ir_q[20:16];
  assign rd   = ir_q[15:11];
  assign fn   = ir_q[5:0];
  assign sext = {{16{ir_q[15]}}, ir_q[15:0]};

  assign is_r   = (op == 6'h00);
  assign i_add  = is_r && (fn == 6'h20);
  assign i_sub  = is_r && (fn == 6'h22);
  assign i_and  = is_r && (fn == 6'h24);
  assign i_or   = is_r && (fn == 6'h25);
  assign i_slt  = is_r && (fn == 6'h2A);
  assign i_jr   = is_r && (fn == 6'h08);
  assign i_addi = (op == 6'h08);
  assign i_lw   = (op == 6'h23);
  assign i_sw   = (op == 6'h2B);
  assign i_beq  = (op == 6'h04);
  assign i_bne  = (op == 6'h05);
  assign i_j    = (op == 6'h02);
  assign i_jal  = (op == 6'h03);

  assign legal = i_add | i_sub | i_and | i_or | i_slt | i_jr |
                 i_addi | i_lw | i_sw | i_beq | i_bne |
                 i_j | i_jal;

  assign rs_val = (rs == 5'd0) ? 32'd0 : rf[rs];
  assign rt_val = (rt == 5'd0) ? 32'd0 : rf[rt];

  assign br_take = i_beq ? (a_q == b_q) : (a_q != b_q);

  // ALU: R-type ops, otherwise base + immediate
  always_comb begin
    alu_res = a_q + sext;
    unique case (1'b1)
      i_add:   alu_res = a_q + b_q;
      i_sub:   alu_res = a_q - b_q;
      i_and:   alu_res = a_q & b_q;
      i_or:    alu_res = a_q | b_q;
      i_slt:   alu_res = {31'd0, $signed(a_q) < $signed(b_q)};
      default: alu_res = a_q + sext;
    endcase
  end

  // Next-state logic; a redirect to FETCH issues the fetch request
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    alu_d    = alu_q;
    mdr_d    = mdr_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    fault_d  = fault_q;
    retire   = 1'b0;
    rf_we    = 1'b0;
    rf_wa    = 5'd0;
    rf_wd    = 32'd0;
    go_fetch = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (!req_q) begin
          req_d  = 1'b1;
          we_d   = 1'b0;
          addr_d = pc_q[ADDR_W-1:0];
        end else if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 32'd4;
          req_d   = 1'b0;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d   = rs_val;
        b_d   = rt_val;
        alu_d = pc_q + {sext[29:0], 2'b00};
        if (!legal) begin
          state_d = S_FAULT;
        end else if (i_j || i_jal) begin
          pc_d     = {pc_q[31:28], ir_q[25:0], 2'b00};
          retire   = 1'b1;
          go_fetch = 1'b1;
          rf_we    = i_jal;
          rf_wa    = 5'd31;
          rf_wd    = pc_q;
        end else if (i_jr) begin
          pc_d     = rs_val;
          retire   = 1'b1;
          go_fetch = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_d = alu_res;
        if (i_beq || i_bne) begin
          if (br_take) pc_d = alu_q;
          retire   = 1'b1;
          go_fetch = 1'b1;
        end else if ((i_lw || i_sw) && (alu_res[1:0] != 2'b00)) begin
          state_d = S_FAULT;
        end else if (i_lw || i_sw) begin
          state_d = S_MEM;
          req_d   = 1'b1;
          we_d    = i_sw;
          addr_d  = alu_res[ADDR_W-1:0];
          wdata_d = b_q;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          req_d = 1'b0;
          we_d  = 1'b0;
          if (i_sw) begin
            retire   = 1'b1;
            go_fetch = 1'b1;
          end else begin
            mdr_d   = mem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we    = 1'b1;
        rf_wa    = is_r ? rd : rt;
        rf_wd    = i_lw ? mdr_q : alu_q;
        retire   = 1'b1;
        go_fetch = 1'b1;
      end
      S_FAULT: begin
        fault_d = 1'b1;
        if (HALT_ON_FAULT) state_d = S_HALT;
        else go_fetch = 1'b1;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
    if (go_fetch) begin
      state_d = S_FETCH;
      req_d   = 1'b1;
      we_d    = 1'b0;
      addr_d  = pc_d[ADDR_W-1:0];
    end
  end

  // Architectural and memory-port state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      fault_q <= fault_d;
    end
  end

  // Register file survives reset; $0 is never written
  always_ff @(posedge clk) begin
    if (rf_we && (rf_wa != 5'd0)) rf[rf_wa] <= rf_wd;
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign fault     = fault_q;
  assign halted    = (state_q == S_HALT);
  assign pc_out    = pc_q;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Random-program bench for mips_multicycle_core: an ISA model predicts
// the memory transactions and per-instruction latency/retire/fault.
module tb_mips_multicycle_core;

  localparam logic [31:0] SPIN = {6'h04, 5'd0, 5'd0, 16'hFFFF};
  localparam int PBASE = 64;
  localparam int PEND  = 200;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready = 1'b0;
  logic        retire, fault, halted;
  logic [31:0] pc_out;

  logic [31:0] mem [1024];
  logic [31:0] mm  [1024];

  int nvec = 0;
  int nbad = 0;
  bit mon_en = 1'b0;
  bit stall_wr = 1'b0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
    bit          fetch;
  } txn_t;

  typedef struct {
    int cyc;
    int ret;
    bit flt;
  } inf_t;

  txn_t txn_q[$];
  inf_t info_q[$];

  mips_multicycle_core #(
    .RESET_PC(32'h100),
    .ADDR_W(32),
    .HALT_ON_FAULT(1'b0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .retire(retire),
    .fault(fault),
    .halted(halted),
    .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[11:2]];

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic logic [31:0] enc_r(int fn, int rs, int rt, int rd);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] enc_j(int op, logic [31:0] tgt);
    return {6'(op), tgt[27:2]};
  endfunction

  // Memory responder: random wait states, commits stores on handshake
  always @(negedge clk) begin
    if (stall_wr && mem_we) mem_ready = 1'b0;
    else mem_ready = ($urandom_range(0, 2) != 0);
    if (mem_req && mem_ready && mem_we)
      mem[mem_addr[11:2]] = mem_wdata;
  end

  // Monitor: handshake scoreboard, request stability, latency
  int          cyc, lastf, waits, rets;
  bit          have_f, pstall;
  logic [31:0] paddr, pwd;
  logic        pwe;

  always @(negedge clk) begin
    txn_t e;
    inf_t f;
    #1;
    if (!mon_en) begin
      have_f = 0;
      pstall = 0;
      cyc = 0;
    end else begin
      cyc++;
      if (retire) rets++;
      if (mem_req && !mem_ready) waits++;
      if (pstall) begin
        chk("hold_req", 32'(mem_req), 32'd1);
        chk("hold_addr", mem_addr, paddr);
        chk("hold_we", 32'(mem_we), 32'(pwe));
        chk("hold_wdata", mem_wdata, pwd);
      end
      pstall = mem_req && !mem_ready;
      paddr = mem_addr;
      pwd = mem_wdata;
      pwe = mem_we;
      if (mem_req && mem_ready) begin
        if (txn_q.size() == 0) begin
          nvec++;
          nbad++;
          $display("FAIL extra_txn: got addr %h expected none",
                   mem_addr);
        end else begin
          e = txn_q.pop_front();
          chk("addr", mem_addr, e.addr);
          chk("we", 32'(mem_we), 32'(e.we));
          if (e.we) chk("wdata", mem_wdata, e.wd);
          if (e.fetch) begin
            chk("pc_out", pc_out, e.addr);
            if (have_f && info_q.size() != 0) begin
              f = info_q.pop_front();
              chk("cycles", 32'(cyc - lastf - waits), 32'(f.cyc));
              chk("retires", 32'(rets), 32'(f.ret));
              chk("fault", 32'(fault), 32'(f.flt));
            end
            have_f = 1;
            lastf = cyc;
            waits = 0;
            rets = 0;
          end
        end
      end
    end
  end

  task automatic put(inout int i, input logic [31:0] w);
    mem[PBASE + i] = w;
    mm[PBASE + i] = w;
    i++;
  endtask

  task automatic gen_prog();
    int i = 0;
    int k, kind, off;
    for (int j = 0; j < 1024; j++) begin
      mem[j] = '0;
      mm[j] = '0;
    end
    for (int j = 512; j < 768; j++) begin
      mem[j] = $urandom;
      mm[j] = mem[j];
    end
    for (int r = 1; r < 8; r++)
      put(i, enc_i(8, 0, r, int'($urandom_range(0, 65535))));
    put(i, enc_r(32, 1, 1, 0));
    put(i, enc_i(43, 0, 0, 'h800));
    put(i, enc_i(8, 0, 1, 5));
    put(i, enc_i(8, 1, 2, -7));
    put(i, enc_i(43, 0, 2, 8));
    put(i, enc_i(35, 0, 3, 2));
    put(i, enc_i(5, 1, 1, 3));
    put(i, enc_i(43, 0, 2, 'h804));
    while (i < PEND) begin
      kind = int'($urandom_range(0, 15));
      k = int'($urandom_range(0, 2));
      if (k > PEND - (i + 1)) k = PEND - (i + 1);
      off = 'h800 + 4 * int'($urandom_range(0, 63));
      if (kind <= 5 || kind == 15)
        put(i, enc_r(int'(kind == 0 ? 'h20 : kind == 1 ? 'h22 :
                          kind == 2 ? 'h24 : kind == 3 ? 'h25 :
                          kind == 4 ? 'h2A : 'h20),
                     int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 7))));
      else if (kind == 6)
        put(i, enc_i(8, int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 65535))));
      else if (kind == 7)
        put(i, enc_i(35, 0, int'($urandom_range(1, 7)), off));
      else if (kind == 8)
        put(i, enc_i(43, 0, int'($urandom_range(0, 7)), off));
      else if (kind == 9)
        put(i, enc_i($urandom_range(0, 1) ? 35 : 43, 0,
                     int'($urandom_range(1, 7)),
                     off + int'($urandom_range(1, 3))));
      else if (kind == 10 || kind == 11)
        put(i, enc_i(kind == 10 ? 4 : 5,
                     int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 7)), k));
      else if (kind == 12)
        put(i, enc_j(2, 32'h100 + 32'(4 * (i + 1 + k))));
      else if (kind == 13 && i + 3 <= PEND) begin
        put(i, enc_j(3, 32'h100 + 32'(4 * (i + 2))));
        put(i, enc_j(2, 32'h100 + 32'(4 * (i + 2))));
        put(i, enc_r(8, 31, 0, 0));
      end else if (kind == 14)
        put(i, $urandom_range(0, 1) ? enc_i(63, 0, 0, 0) :
               enc_r(0, int'($urandom_range(1, 7)),
                     int'($urandom_range(1, 7)), 1));
      else
        put(i, enc_i(8, 0, 1, int'($urandom_range(0, 65535))));
    end
    put(i, SPIN);
  endtask

  // ISA-level reference: one loop iteration per instruction
  task automatic run_model();
    logic [31:0] R [32];
    logic [31:0] pc, npc, ir, a, b, se, ea;
    int spins = 0;
    int steps = 0;
    bit mf = 0;
    foreach (R[r]) R[r] = '0;
    pc = 32'h100;
    while (spins < 3 && steps < 3000) begin
      int c;
      bit bad;
      ir = mm[pc[11:2]];
      txn_q.push_back('{pc, 1'b0, 32'h0, 1'b1});
      a = R[ir[25:21]];
      b = R[ir[20:16]];
      se = 32'($signed(ir[15:0]));
      ea = a + se;
      npc = pc + 4;
      bad = 0;
      c = 4;
      if (ir == SPIN) spins++;
      case (ir[31:26])
        6'h00: case (ir[5:0])
          6'h20: R[ir[15:11]] = a + b;
          6'h22: R[ir[15:11]] = a - b;
          6'h24: R[ir[15:11]] = a & b;
          6'h25: R[ir[15:11]] = a | b;
          6'h2A: R[ir[15:11]] = ($signed(a) < $signed(b)) ? 1 : 0;
          6'h08: begin npc = a; c = 2; end
          default: begin bad = 1; c = 3; end
        endcase
        6'h08: R[ir[20:16]] = ea;
        6'h23: begin
          if (ea[1:0] != 0) bad = 1;
          else begin
            txn_q.push_back('{ea, 1'b0, b, 1'b0});
            R[ir[20:16]] = mm[ea[11:2]];
            c = 5;
          end
        end
        6'h2B: begin
          if (ea[1:0] != 0) bad = 1;
          else begin
            txn_q.push_back('{ea, 1'b1, b, 1'b0});
            mm[ea[11:2]] = b;
          end
        end
        6'h04: begin c = 3; if (a == b) npc = pc + 4 + (se << 2); end
        6'h05: begin c = 3; if (a != b) npc = pc + 4 + (se << 2); end
        6'h02: begin c = 2; npc = {npc[31:28], ir[25:0], 2'b00}; end
        6'h03: begin
          c = 2;
          R[31] = pc + 4;
          npc = {npc[31:28], ir[25:0], 2'b00};
        end
        default: begin bad = 1; c = 3; end
      endcase
      R[0] = '0;
      if (bad) mf = 1;
      info_q.push_back('{c, bad ? 0 : 1, mf});
      pc = npc;
      steps++;
    end
  endtask

  initial begin
    int t;
    for (int j = 0; j < 1024; j++) mem[j] = '0;
    mem[PBASE] = enc_i(43, 0, 0, 'h10);
    stall_wr = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_retire", 32'(retire), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_pc", pc_out, 32'h100);
    reset = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      #2;
      t++;
    end while (!(mem_req && mem_we) && t < 50);
    if (t >= 50) begin
      nvec++;
      nbad++;
      $display("FAIL store_timeout: got no store, expected one");
    end
    chk("st_addr", mem_addr, 32'h10);
    chk("st_wdata", mem_wdata, 32'd0);
    repeat (3) @(negedge clk);
    #2;
    chk("st_held_req", 32'(mem_req), 32'd1);
    chk("st_held_addr", mem_addr, 32'h10);
    reset = 1'b0;
    #1;
    chk("rst_mid_req", 32'(mem_req), 32'd0);
    chk("rst_mid_we", 32'(mem_we), 32'd0);
    chk("rst_mid_pc", pc_out, 32'h100);
    stall_wr = 1'b0;
    gen_prog();
    run_model();
    mon_en = 1'b1;
    @(negedge clk);
    #3;
    reset = 1'b1;
    t = 0;
    while (txn_q.size() != 0 && t < 30000) begin
      @(negedge clk);
      #2;
      t++;
    end
    mon_en = 1'b0;
    if (txn_q.size() != 0) begin
      nvec++;
      nbad++;
      $display("FAIL run_timeout: got %0d pending, expected 0",
               txn_q.size());
    end
    chk("end_halted", 32'(halted), 32'd0);
    chk("end_fault", 32'(fault), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
